align_normalizer_pipe: RTL and testbench

ALIGN_NORMALIZER_PIPE -- requirements
Module: align_normalizer_pipe

---
 rtl/align_normalizer_pipe.sv | 149 ++++++++++++++
 tb/tb_align_normalizer_pipe.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/align_normalizer_pipe.sv
// Aligns N lane mantissas to the largest enabled exponent, with per-lane sticky.
// Latency: 2 cycles (S1 = max tree + capture, S2 = shift + sticky), full throughput.
// Backpressure: out_ready low stalls S2, then S1; in_ready falls once both stages hold beats.
module align_normalizer_pipe #(
    parameter int N      = 8,
    parameter int EXP_W  = 8,
    parameter int MANT_W = 23
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [N-1:0]                   lane_en,
    input  logic [N*EXP_W-1:0]             exp,
    input  logic [N*(MANT_W+1)-1:0]        mant,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [EXP_W-1:0]               exp_max,
    output logic [N*(2*MANT_W+1)-1:0]      out,
    output logic [N-1:0]                   sticky,
    output logic                           all_off
);

    localparam int MW     = MANT_W + 1;
    localparam int OUT_W  = 2 * MANT_W + 1;
    localparam int LEVELS = $clog2(N);

    // Disabled lanes enter the max tree at the most negative exponent.
    localparam logic [EXP_W-1:0] EXP_MIN = {1'b1, {(EXP_W-1){1'b0}}};

    // Number of live nodes at a given tree level (ceil(N / 2^l)).
    function automatic int lvl_cnt(input int l);
        return (N + (1 << l) - 1) >> l;
    endfunction

    logic run;
    logic s1_valid;
    logic s2_valid;
    logic s1_adv;
    logic s2_adv;

    logic [N-1:0]        s1_en;
    logic [N*EXP_W-1:0]  s1_exp;
    logic [N*MW-1:0]     s1_mant;
    logic [EXP_W-1:0]    s1_max;
    logic                s1_off;

    logic [N*OUT_W-1:0]  nxt_out;
    logic [N-1:0]        nxt_sticky;

    // Handshake: a stage moves when its successor can take the beat.
    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = run && s1_adv;
    assign out_valid = s2_valid;

    // Signed max tree; an unpaired node at an odd-width level is passed through.
    logic signed [EXP_W-1:0] tree [0:LEVELS][0:N-1];

    for (genvar k = 0; k < N; k++) begin : g_leaf
        assign tree[0][k] = lane_en[k] ? exp[k*EXP_W +: EXP_W] : EXP_MIN;
    end

    for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
        for (genvar k = 0; k < N; k++) begin : g_node
            if (k < lvl_cnt(l + 1)) begin : g_live
                if (2 * k + 1 < lvl_cnt(l)) begin : g_pair
                    assign tree[l+1][k] = (tree[l][2*k] >= tree[l][2*k+1]) ?
                                          tree[l][2*k] : tree[l][2*k+1];
                end else begin : g_pass
                    assign tree[l+1][k] = tree[l][2*k];
                end
            end else begin : g_dead
                assign tree[l+1][k] = EXP_MIN;
            end
        end
    end

    // in_ready stays low during reset and rises on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run <= 1'b0;
        else        run <= 1'b1;
    end

    // Stage valid flags: clear on advance when no beat is moving in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s1_adv) s1_valid <= in_valid && in_ready;
            if (s2_adv) s2_valid <= s1_valid;
        end
    end

    // S1 captures the lane data and the reduced max exponent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_en   <= '0;
            s1_exp  <= '0;
            s1_mant <= '0;
            s1_max  <= '0;
            s1_off  <= 1'b0;
        end else if (in_valid && in_ready) begin
            s1_en   <= lane_en;
            s1_exp  <= exp;
            s1_mant <= mant;
            s1_max  <= (lane_en == '0) ? '0 : tree[LEVELS][0];
            s1_off  <= (lane_en == '0);
        end
    end

    // Per-lane alignment: the difference is one bit wider so it never wraps.
    always_comb begin
        logic [EXP_W:0]   diff;
        logic [OUT_W-1:0] full;
        logic [EXP_W-1:0] e;
        diff       = '0;
        full       = '0;
        e          = '0;
        nxt_out    = '0;
        nxt_sticky = '0;
        for (int i = 0; i < N; i++) begin
            e    = s1_exp[i*EXP_W +: EXP_W];
            diff = {s1_max[EXP_W-1], s1_max} - {e[EXP_W-1], e};
            full = {s1_mant[i*MW +: MW], {MANT_W{1'b0}}};
            if (s1_en[i]) begin
                nxt_out[i*OUT_W +: OUT_W] = full >> diff;
                nxt_sticky[i]             = |(full & ~({OUT_W{1'b1}} << diff));
            end
        end
    end

    // S2 output registers hold while the downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out     <= '0;
            sticky  <= '0;
            exp_max <= '0;
            all_off <= 1'b0;
        end else if (s2_adv && s1_valid) begin
            out     <= nxt_out;
            sticky  <= nxt_sticky;
            exp_max <= s1_max;
            all_off <= s1_off;
        end
    end

endmodule

// File: tb/tb_align_normalizer_pipe.sv
module tb_align_normalizer_pipe;

    localparam int N  = 8;
    localparam int EW = 8;
    localparam int MW = 24;
    localparam int OW = 47;
    localparam int NV = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic                   out_valid;
    logic                   out_ready;
    logic                   all_off;
    logic [N-1:0]           lane_en;
    logic [N-1:0]           sticky;
    logic [N-1:0][EW-1:0]   exp_s;
    logic [N-1:0][MW-1:0]   mant_s;
    logic [EW-1:0]          exp_max;
    logic [N-1:0][OW-1:0]   out_s;

    logic                   in_ready5;
    logic                   out_valid5;
    logic                   all_off5;
    logic [4:0]             lane_en5;
    logic [4:0]             sticky5;
    logic [4:0][EW-1:0]     exp5;
    logic [4:0][MW-1:0]     mant5;
    logic [EW-1:0]          exp_max5;
    logic [4:0][OW-1:0]     out5;

    align_normalizer_pipe u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .lane_en(lane_en), .exp(exp_s), .mant(mant_s), .out_valid(out_valid),
        .out_ready(out_ready), .exp_max(exp_max), .out(out_s), .sticky(sticky),
        .all_off(all_off)
    );

    align_normalizer_pipe #(.N(5)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready5),
        .lane_en(lane_en5), .exp(exp5), .mant(mant5), .out_valid(out_valid5),
        .out_ready(out_ready), .exp_max(exp_max5), .out(out5), .sticky(sticky5),
        .all_off(all_off5)
    );

    typedef struct {
        logic [N-1:0]         en;
        logic [N-1:0][EW-1:0] e;
        logic [N-1:0][MW-1:0] m;
        logic [EW-1:0]        xmax;
        logic                 xoff;
        logic [N-1:0]         xst;
        logic [N-1:0][OW-1:0] xout;
    } vec_t;

    vec_t vt [NV];

    int checks = 0;
    int errors = 0;

    int q[$];
    int nxt;
    int fo;
    int delivered;
    int idx;
    logic                 held_v;
    logic [EW-1:0]        h_max;
    logic [N-1:0][OW-1:0] h_out;
    logic [N-1:0]         h_st;
    logic                 h_off;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_vec(input int i);
        lane_en  = vt[i].en;
        exp_s    = vt[i].e;
        mant_s   = vt[i].m;
        in_valid = 1'b1;
    endtask

    task automatic check_vec(input int i, input string tag);
        chk($sformatf("%s%0d_exp_max", tag, i), exp_max, vt[i].xmax);
        chk($sformatf("%s%0d_all_off", tag, i), all_off, vt[i].xoff);
        chk($sformatf("%s%0d_sticky", tag, i), sticky, vt[i].xst);
        for (int l = 0; l < N; l++)
            chk($sformatf("%s%0d_out%0d", tag, i, l), out_s[l], vt[i].xout[l]);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int v = 0; v < NV; v++) begin
            vt[v].en = '0; vt[v].e = '0; vt[v].m = '0; vt[v].xmax = '0;
            vt[v].xoff = 1'b0; vt[v].xst = '0; vt[v].xout = '0;
        end
        // V0: all lanes equal
        vt[0].en = 8'hFF; vt[0].xmax = 8'd5;
        for (int l = 0; l < N; l++) begin
            vt[0].e[l] = 8'd5; vt[0].m[l] = 24'h800000; vt[0].xout[l] = 47'h4000_0000_0000;
        end
        // V1: mixed exponents, lane 3 far below the max
        vt[1].en = 8'hFF; vt[1].xmax = 8'd10; vt[1].xst = 8'h08;
        vt[1].e[0] = 8'd10; vt[1].e[1] = 8'd7; vt[1].e[2] = 8'd10; vt[1].e[3] = 8'h80;
        for (int l = 0; l < N; l++) vt[1].m[l] = 24'h800000;
        vt[1].m[1] = 24'h800001; vt[1].m[2] = 24'hC00000; vt[1].m[7] = 24'hFFFFFF;
        vt[1].xout[0] = 47'h4000_0000_0000; vt[1].xout[1] = 47'h800_0010_0000;
        vt[1].xout[2] = 47'h6000_0000_0000; vt[1].xout[3] = 47'h0;
        vt[1].xout[4] = 47'h10_0000_0000;  vt[1].xout[5] = 47'h10_0000_0000;
        vt[1].xout[6] = 47'h10_0000_0000;  vt[1].xout[7] = 47'h1F_FFFF_E000;
        // V2: sticky from partial shift, diff = OUT_W-1 and OUT_W, disabled big lane
        vt[2].en = 8'hBF; vt[2].xmax = 8'd30; vt[2].xst = 8'h0A;
        vt[2].e[0] = 8'd30; vt[2].e[1] = 8'd0;  vt[2].e[2] = 8'hF0; vt[2].e[3] = 8'hEF;
        vt[2].e[4] = 8'hEF; vt[2].e[5] = 8'd30; vt[2].e[6] = 8'd100; vt[2].e[7] = 8'd29;
        vt[2].m[0] = 24'h800000; vt[2].m[1] = 24'h800001; vt[2].m[2] = 24'h800000;
        vt[2].m[3] = 24'h800000; vt[2].m[4] = 24'h000000; vt[2].m[5] = 24'h123456;
        vt[2].m[6] = 24'hFFFFFF; vt[2].m[7] = 24'hFFFFFF;
        vt[2].xout[0] = 47'h4000_0000_0000; vt[2].xout[1] = 47'h1_0000;
        vt[2].xout[2] = 47'h1; vt[2].xout[5] = 47'h91A_2B00_0000;
        vt[2].xout[7] = 47'h3FFF_FFC0_0000;
        // V3: single enabled lane with negative exponent
        vt[3].en = 8'h01; vt[3].xmax = 8'hFD;
        for (int l = 0; l < N; l++) begin
            vt[3].e[l] = 8'd100; vt[3].m[l] = 24'hABCDEF;
        end
        vt[3].e[0] = 8'hFD; vt[3].xout[0] = 47'h55E6_F780_0000;
        // V4: all lanes disabled
        vt[4].xoff = 1'b1;
        for (int l = 0; l < N; l++) begin
            vt[4].e[l] = 8'h40 + 8'(l); vt[4].m[l] = 24'hFFFFFF;
        end
        // V5: 127 vs -128, difference 255 without wrap
        vt[5].en = 8'h03; vt[5].xmax = 8'h7F; vt[5].xst = 8'h02;
        for (int l = 0; l < N; l++) begin
            vt[5].e[l] = 8'h7F; vt[5].m[l] = 24'hFFFFFF;
        end
        vt[5].e[1] = 8'h80; vt[5].m[0] = 24'h800000; vt[5].m[1] = 24'h000001;
        vt[5].xout[0] = 47'h4000_0000_0000;
        // V6: every lane at the most negative exponent
        vt[6].en = 8'hFF; vt[6].xmax = 8'h80;
        for (int l = 0; l < N; l++) begin
            vt[6].e[l] = 8'h80; vt[6].m[l] = 24'h800000; vt[6].xout[l] = 47'h4000_0000_0000;
        end
        vt[6].m[2] = 24'h0; vt[6].xout[2] = 47'h0;

        lane_en5 = 5'h1F;
        exp5[0] = 8'd1; exp5[1] = 8'd9; exp5[2] = 8'd3; exp5[3] = 8'd9; exp5[4] = 8'd2;
        mant5[0] = 24'h800000; mant5[1] = 24'hABCDEF; mant5[2] = 24'hFFFFFF;
        mant5[3] = 24'h800001; mant5[4] = 24'h000001;

        // Reset state
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        lane_en = '0; exp_s = '0; mant_s = '0;
        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_exp_max", exp_max, 0);
        chk("rst_sticky", sticky, 0);
        chk("rst_all_off", all_off, 0);
        chk("rst_out_zero", |out_s, 0);
        chk("rst_in_ready5", in_ready5, 0);
        #10 rst_n = 1'b1;
        #1 chk("rel_in_ready_before_edge", in_ready, 0);
        tick();
        chk("rel_in_ready_after_edge", in_ready, 1);

        // Back-to-back stream of the whole table
        for (int c = 0; c <= NV; c++) begin
            if (c < NV) begin
                apply_vec(c);
                #1 chk($sformatf("tp_in_ready%0d", c), in_ready, 1);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (c == 0) begin
                chk("tp_latency_not_1", out_valid, 0);
            end else begin
                chk($sformatf("tp_out_valid%0d", c - 1), out_valid, 1);
                check_vec(c - 1, "tp");
            end
            if (c == 2) begin
                chk("n5_out_valid", out_valid5, 1);
                chk("n5_exp_max", exp_max5, 8'd9);
                chk("n5_all_off", all_off5, 0);
                chk("n5_sticky", sticky5, 0);
                chk("n5_out0", out5[0], 47'h40_0000_0000);
                chk("n5_out1", out5[1], 47'h55E6_F780_0000);
                chk("n5_out2", out5[2], 47'h1FF_FFFE_0000);
                chk("n5_out3", out5[3], 47'h4000_0080_0000);
                chk("n5_out4", out5[4], 47'h1_0000);
            end
        end
        tick();
        chk("tp_drain", out_valid, 0);

        // Four beats with a 3-cycle downstream stall after the first output
        nxt = 0; fo = -1; delivered = 0; held_v = 1'b0;
        h_max = '0; h_out = '0; h_st = '0; h_off = 1'b0;
        for (int t = 0; t < 20; t++) begin
            if (nxt < 4) apply_vec(nxt);
            else in_valid = 1'b0;
            if (fo < 0 && out_valid) fo = t;
            out_ready = !(fo >= 0 && t < fo + 3);
            #1;
            if (held_v) begin
                chk("stall_hold_valid", out_valid, 1);
                chk("stall_hold_exp_max", exp_max, h_max);
                chk("stall_hold_out", (out_s == h_out), 1);
                chk("stall_hold_sticky", sticky, h_st);
                chk("stall_hold_all_off", all_off, h_off);
            end
            if (fo >= 0 && t == fo + 2) chk("stall_in_ready_low", in_ready, 0);
            if (out_valid && out_ready) begin
                chk("stall_no_extra_beat", (q.size() != 0), 1);
                if (q.size() != 0) begin
                    idx = q.pop_front();
                    check_vec(idx, "stall");
                    delivered++;
                end
            end
            held_v = out_valid && !out_ready;
            h_max = exp_max; h_out = out_s; h_st = sticky; h_off = all_off;
            if (in_valid && in_ready) begin
                q.push_back(nxt);
                nxt++;
            end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("stall_delivered", delivered, 4);
        chk("stall_idle_after", out_valid, 0);

        // Asynchronous reset with two beats in flight
        apply_vec(0);
        tick();
        apply_vec(1);
        tick();
        in_valid = 1'b0;
        chk("rm_pre_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rm_async_out_valid", out_valid, 0);
        chk("rm_async_in_ready", in_ready, 0);
        chk("rm_async_exp_max", exp_max, 0);
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1 chk("rm_in_ready_before_edge", in_ready, 0);
        tick();
        chk("rm_in_ready_after_edge", in_ready, 1);
        chk("rm_no_stale1", out_valid, 0);
        tick();
        chk("rm_no_stale2", out_valid, 0);
        apply_vec(4);
        tick();
        in_valid = 1'b0;
        chk("rm_new_latency1", out_valid, 0);
        tick();
        chk("rm_new_valid", out_valid, 1);
        check_vec(4, "rm");
        tick();
        chk("rm_final_idle", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
